// File: rtl/phy_rx_deser_if.sv
`default_nettype none
// ============================================================================
//  Module   : phy_rx_deser_if
//  Brief    : Serial-in / 4-lane-out bundle for the PHY receive deserializer.
//  Revision : 1.0  initial release
// ============================================================================
interface phy_rx_deser_if;
    logic       serial_in;
    logic [7:0] IDLE;
    logic [7:0] out0;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [7:0] out3;
    logic       valid_out0;
    logic       valid_out1;
    logic       valid_out2;
    logic       valid_out3;
    logic       active;

    // master drives the serial link, slave is the deserializer
    modport master (
        output serial_in, IDLE,
        input  out0, out1, out2, out3,
        input  valid_out0, valid_out1, valid_out2, valid_out3,
        input  active
    );

    modport slave (
        input  serial_in, IDLE,
        output out0, out1, out2, out3,
        output valid_out0, valid_out1, valid_out2, valid_out3,
        output active
    );
endinterface
`default_nettype wire

// File: rtl/phy_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module   : phy_rx_deser
//  Brief    : Bit-serial receiver; locks on a run of IDLE bytes, then demuxes
//             bytes round-robin into four lanes with one frame per 32 bits.
//  Revision : 1.0  initial release
// ============================================================================
module phy_rx_deser #(
    parameter int BC_COUNT = 4
) (
    input  wire logic      clk_32f,
    input  wire logic      rst,
    phy_rx_deser_if.slave  link
);

    localparam logic [3:0] c_LOCK_CNT = 4'(BC_COUNT - 1);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [2:0] r_bit_cnt;
    logic [1:0] r_lane_cnt;
    logic [3:0] r_idle_cnt;
    logic [6:0] r_shift;

    logic [7:0] r_stage [3];
    logic [2:0] r_stage_v;

    logic [7:0] r_out [4];
    logic [3:0] r_valid;

    logic       w_byte_done;
    logic [7:0] w_rx_byte;
    logic       w_is_idle;
    logic       w_stage_en;
    logic       w_frame_end;

    // The byte completes in the same cycle its last bit arrives.
    assign w_byte_done = (r_bit_cnt == 3'd7);
    assign w_rx_byte   = {r_shift, link.serial_in};
    assign w_is_idle   = (w_rx_byte == link.IDLE);

    always_ff @(posedge clk_32f or negedge rst) begin
        if (!rst) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stage_en   = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_byte_done && w_is_idle && (r_idle_cnt == c_LOCK_CNT)) begin
                    w_state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                w_state_next = ST_ACTIVE;
                if (w_byte_done) begin
                    w_stage_en  = 1'b1;
                    w_frame_end = (r_lane_cnt == 2'd3);
                end
            end
            default: begin
                w_state_next = ST_SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge rst) begin
        if (!rst) begin
            r_bit_cnt  <= 3'd0;
            r_lane_cnt <= 2'd0;
            r_idle_cnt <= 4'd0;
            r_shift    <= 7'd0;
        end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_shift   <= w_rx_byte[6:0];
            if (w_byte_done) begin
                r_lane_cnt <= r_lane_cnt + 2'd1;
            end
            if ((r_state == ST_SEARCH) && w_byte_done) begin
                r_idle_cnt <= w_is_idle ? (r_idle_cnt + 4'd1) : 4'd0;
            end
        end
    end

    // Lane 3 never needs staging: it goes straight to out3 at frame end.
    always_ff @(posedge clk_32f or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                r_stage[i] <= 8'h00;
            end
            for (int i = 0; i < 4; i++) begin
                r_out[i] <= 8'h00;
            end
            r_stage_v <= 3'b000;
            r_valid   <= 4'b0000;
        end else begin
            if (w_stage_en) begin
                case (r_lane_cnt)
                    2'd0: begin
                        r_stage[0]   <= w_rx_byte;
                        r_stage_v[0] <= !w_is_idle;
                    end
                    2'd1: begin
                        r_stage[1]   <= w_rx_byte;
                        r_stage_v[1] <= !w_is_idle;
                    end
                    2'd2: begin
                        r_stage[2]   <= w_rx_byte;
                        r_stage_v[2] <= !w_is_idle;
                    end
                    default: begin
                    end
                endcase
            end
            if (w_frame_end) begin
                r_out[0]  <= r_stage[0];
                r_out[1]  <= r_stage[1];
                r_out[2]  <= r_stage[2];
                r_out[3]  <= w_rx_byte;
                r_valid   <= {!w_is_idle, r_stage_v};
                r_stage_v <= 3'b000;
            end
        end
    end

    assign link.out0       = r_out[0];
    assign link.out1       = r_out[1];
    assign link.out2       = r_out[2];
    assign link.out3       = r_out[3];
    assign link.valid_out0 = r_valid[0];
    assign link.valid_out1 = r_valid[1];
    assign link.valid_out2 = r_valid[2];
    assign link.valid_out3 = r_valid[3];
    assign link.active     = (r_state == ST_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_phy_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phy_rx_deser
//  Brief    : Self-checking bench for phy_rx_deser (vector table + scoreboard).
//  Revision : 1.0  initial release
// ============================================================================
module tb_phy_rx_deser;

    localparam logic [7:0] c_IDLE = 8'hBC;

    logic clk_32f;
    logic rst;
    int   n_vec;
    int   n_miss;

    // {out0,out1,out2,out3,v0,v1,v2,v3}
    logic [35:0] sb_q [$];
    logic [35:0] last_exp;

    typedef struct {
        logic [31:0] bytes;
        logic [31:0] exp_out;
        logic [3:0]  exp_v;
    } vec_t;

    vec_t vecs [6];

    phy_rx_deser_if bus ();

    phy_rx_deser #(.BC_COUNT(4)) dut (
        .clk_32f (clk_32f),
        .rst     (rst),
        .link    (bus)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [35:0] dut_frame();
        return {bus.out0, bus.out1, bus.out2, bus.out3,
                bus.valid_out0, bus.valid_out1, bus.valid_out2, bus.valid_out3};
    endfunction

    task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_active(input string nm, input logic exp);
        check(nm, {35'd0, bus.active}, {35'd0, exp});
    endtask

    task automatic send_bit(input logic b);
        bus.serial_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic pop_check(input string nm);
        logic [35:0] e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: got output frame expected none queued", nm);
        end else begin
            e = sb_q.pop_front();
            check(nm, dut_frame(), e);
            last_exp = e;
        end
    endtask

    // Sends one aligned frame; outputs must hold the previous frame until lane 3 ends.
    task automatic send_frame(input logic [31:0] bytes, input logic [35:0] exp, input string nm);
        sb_q.push_back(exp);
        for (int l = 0; l < 3; l++) begin
            send_byte(bytes[31-8*l -: 8]);
            check({nm, "_hold"}, dut_frame(), last_exp);
        end
        send_byte(bytes[7:0]);
        pop_check(nm);
    endtask

    task automatic do_reset();
        bus.serial_in = 1'b0;
        rst = 1'b0;
        #1;
        check_active("rst_active", 1'b0);
        check("rst_outputs", dut_frame(), 36'd0);
        repeat (3) begin
            bus.serial_in = ~bus.serial_in;
            @(posedge clk_32f);
            #1;
        end
        check("rst_hold", dut_frame(), 36'd0);
        sb_q.delete();
        last_exp = 36'd0;
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0]  lock_seq [8];
        logic [7:0]  b [4];
        logic [35:0] e;

        n_vec    = 0;
        n_miss   = 0;
        last_exp = 36'd0;
        bus.IDLE = c_IDLE;
        bus.serial_in = 1'b0;
        rst = 1'b0;

        vecs[0] = '{32'h11223344, 32'h11223344, 4'b1111};
        vecs[1] = '{32'hAABCCCBC, 32'hAABCCCBC, 4'b1010};
        vecs[2] = '{32'hBCBCBCBC, 32'hBCBCBCBC, 4'b0000};
        vecs[3] = '{32'h00FF8001, 32'h00FF8001, 4'b1111};
        vecs[4] = '{32'hBC5ABCA5, 32'hBC5ABCA5, 4'b0101};
        vecs[5] = '{32'hBDBBBCC3, 32'hBDBBBCC3, 4'b1101};

        // T1: reset with toggling input
        @(posedge clk_32f);
        #1;
        do_reset();

        // T2: lock with an interrupted IDLE run
        lock_seq = '{8'hBC, 8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
        for (int k = 0; k < 7; k++) begin
            send_byte(lock_seq[k]);
            check_active($sformatf("lock_byte%0d", k), 1'b0);
        end
        for (int i = 7; i >= 1; i--) send_bit(lock_seq[7][i]);
        check_active("lock_cycle63", 1'b0);
        send_bit(lock_seq[7][0]);
        check_active("lock_cycle64", 1'b1);
        check("lock_outputs", dut_frame(), 36'd0);

        // T3/T4: vector table of aligned frames
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].bytes, {vecs[v].exp_out, vecs[v].exp_v},
                       $sformatf("vec%0d", v));
        end
        check_active("still_active", 1'b1);

        // T5: lock completes on lane 1
        do_reset();
        send_byte(8'h55);
        send_byte(8'h55);
        send_byte(c_IDLE);
        send_byte(c_IDLE);
        send_byte(c_IDLE);
        check_active("midlock_before", 1'b0);
        send_byte(c_IDLE);
        check_active("midlock_after", 1'b1);
        sb_q.push_back({8'h00, 8'h00, 8'h77, c_IDLE, 4'b0010});
        send_byte(8'h77);
        check("midlock_hold", dut_frame(), 36'd0);
        send_byte(c_IDLE);
        pop_check("midlock_frame1");
        send_frame(32'h01020304, {32'h01020304, 4'b1111}, "midlock_frame2");

        // T6: random traffic with a mid-frame reset and relock
        do_reset();
        for (int k = 0; k < 4; k++) send_byte(c_IDLE);
        check_active("relock0", 1'b1);
        for (int f = 0; f < 200; f++) begin
            for (int l = 0; l < 4; l++) begin
                b[l] = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) b[l] = c_IDLE;
            end
            e = {b[0], b[1], b[2], b[3],
                 b[0] != c_IDLE, b[1] != c_IDLE, b[2] != c_IDLE, b[3] != c_IDLE};
            if (f == 100) begin
                send_byte(b[0]);
                for (int i = 7; i >= 5; i--) send_bit(b[1][i]);
                do_reset();
                for (int k = 0; k < 4; k++) send_byte(c_IDLE);
                check_active("relock1", 1'b1);
            end else begin
                send_frame({b[0], b[1], b[2], b[3]}, e, $sformatf("rand%0d", f));
            end
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL sb_drain: got %0d entries expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
